// File: rtl/xfer_sched_pkg.sv
// Shared types and default sizing for the serial-to-queue transfer scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xfer_pkg;

   typedef enum logic [2:0] {IDLE, ENQ, DEQ, SETTLE, ACK} xfer_state_t;

   typedef enum logic {GRANT_ENQ, GRANT_DEQ} grant_t;

   localparam int RATIO_DEF = 10;
   localparam int DEPTH_DEF = 8;
   localparam int LEN_W_DEF = 4;

endpackage

// File: rtl/xfer_sched_if.sv
// Deserializer handshake plus queue port bundle between scheduler and its peers.
// Latency: n/a (wires only).
// Backpressure: ack_out is withheld by the scheduler while the queue is full.
interface xfer_sched_if #(parameter int LEN_W = 4);

   logic             data_ready_in;
   logic [7:0]       deser_data_in;
   logic [LEN_W-1:0] queue_len_in;
   logic             ack_out;
   logic [7:0]       queue_data_out;
   logic             enqueue_out;
   logic             dequeue_out;

   modport master (
      input  data_ready_in, deser_data_in, queue_len_in,
      output ack_out, queue_data_out, enqueue_out, dequeue_out
   );

   modport slave (
      output data_ready_in, deser_data_in, queue_len_in,
      input  ack_out, queue_data_out, enqueue_out, dequeue_out
   );

endinterface

// File: rtl/xfer_sched_len_sync.sv
// Two-flop synchronizer bringing the 10 KHz queue length into clock_100KHZ.
// Latency: 2 cycles.
// Backpressure: none.
module len_sync #(
   parameter int LEN_W = 4
) (
   input  logic             clock_100KHZ,
   input  logic             reset,
   input  logic [LEN_W-1:0] len_in,
   output logic [LEN_W-1:0] len_s
);

   logic [LEN_W-1:0] meta;

   // two-stage capture of the slow-domain occupancy
   always_ff @(posedge clock_100KHZ or posedge reset) begin
      if (reset) begin
         meta  <= '0;
         len_s <= '0;
      end else begin
         meta  <= len_in;
         len_s <= meta;
      end
   end

endmodule

// File: rtl/xfer_sched.sv
// Arbitrates deserializer writes and dequeue requests onto the slow queue port with stretched strobes.
// Latency: eligible -> strobe 1 cycle; strobe RATIO cycles; ack after settle (>=3 cycles) + 1.
// Backpressure: a byte arriving while the queue is full stays pending and ack_out is withheld.
module xfer_sched
   import xfer_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int RATIO   = RATIO_DEF,
   parameter int LEN_W   = LEN_W_DEF,
   parameter int TIMEOUT = 2 * RATIO
) (
   input  logic          clock_100KHZ,
   input  logic          reset,
   input  logic          dequeue_req_in,
   output logic          busy_out,
   output logic          full_out,
   output logic          empty_out,
   output logic          err_out,
   xfer_sched_if.master  bus
);

   localparam int CNT_MAX = (RATIO > TIMEOUT) ? RATIO : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   xfer_state_t      state;
   grant_t           last_grant;
   grant_t           grant_sel;
   logic             grant_vld;
   logic             enq_elig;
   logic             deq_elig;
   logic             deq_pend;
   logic             acked;
   logic [LEN_W-1:0] len_s;
   logic [LEN_W-1:0] len_snap;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       data_q;

   len_sync #(.LEN_W(LEN_W)) u_len_sync (
      .clock_100KHZ (clock_100KHZ),
      .reset        (reset),
      .len_in       (bus.queue_len_in),
      .len_s        (len_s)
   );

   assign full_out           = (len_s == LEN_W'(DEPTH));
   assign empty_out          = (len_s == '0);
   assign busy_out           = (state != IDLE);
   assign bus.enqueue_out    = (state == ENQ);
   assign bus.dequeue_out    = (state == DEQ);
   assign bus.ack_out        = (state == ACK);
   assign bus.queue_data_out = data_q;

   // eligibility and round-robin pick; on contention the op not granted last wins
   always_comb begin
      enq_elig  = bus.data_ready_in && !acked && !full_out;
      deq_elig  = deq_pend && !empty_out;
      grant_vld = enq_elig || deq_elig;
      grant_sel = GRANT_DEQ;
      if (enq_elig && deq_elig)
         grant_sel = (last_grant == GRANT_DEQ) ? GRANT_ENQ : GRANT_DEQ;
      else if (enq_elig)
         grant_sel = GRANT_ENQ;
   end

   // main sequencer: grant, stretch strobe, wait for the length to move, then ack writes
   always_ff @(posedge clock_100KHZ or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         len_snap   <= '0;
         data_q     <= '0;
         last_grant <= GRANT_DEQ;
         err_out    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  last_grant <= grant_sel;
                  len_snap   <= len_s;
                  cnt        <= '0;
                  if (grant_sel == GRANT_ENQ) begin
                     data_q <= bus.deser_data_in;
                     state  <= ENQ;
                  end else begin
                     state  <= DEQ;
                  end
               end
            end
            ENQ, DEQ: begin
               if (cnt == CNT_W'(RATIO - 1)) begin
                  cnt   <= '0;
                  state <= SETTLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SETTLE: begin
               if ((len_s != len_snap) || (cnt == CNT_W'(TIMEOUT - 1))) begin
                  // a length that never moved means the queue did not take the op
                  if (len_s == len_snap)
                     err_out <= 1'b1;
                  cnt   <= '0;
                  state <= ((last_grant == GRANT_ENQ) && bus.data_ready_in) ? ACK : IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // pending dequeue merges repeat requests; acked blocks re-writing the same byte
   always_ff @(posedge clock_100KHZ or posedge reset) begin
      if (reset) begin
         deq_pend <= 1'b0;
         acked    <= 1'b0;
      end else begin
         if ((state == IDLE) && grant_vld && (grant_sel == GRANT_DEQ))
            deq_pend <= 1'b0;
         else if (dequeue_req_in)
            deq_pend <= 1'b1;

         if (state == ACK)
            acked <= 1'b1;
         else if (!bus.data_ready_in)
            acked <= 1'b0;
      end
   end

endmodule

// File: tb/tb_xfer_sched.sv
// Directed bench for xfer_sched with a cycle-stepped queue and deserializer model.
// Latency: n/a.
// Backpressure: model queue saturates at 8 entries.
module tb_xfer_sched;

   logic clock_100KHZ = 1'b0;
   logic reset;
   logic dequeue_req_in;
   logic busy_out, full_out, empty_out, err_out;

   xfer_sched_if #(.LEN_W(4)) q ();

   xfer_sched dut (
      .clock_100KHZ   (clock_100KHZ),
      .reset          (reset),
      .dequeue_req_in (dequeue_req_in),
      .busy_out       (busy_out),
      .full_out       (full_out),
      .empty_out      (empty_out),
      .err_out        (err_out),
      .bus            (q.master)
   );

   always #5 clock_100KHZ = ~clock_100KHZ;

   int n_checks = 0;
   int n_pass   = 0;

   int   len_m = 0;
   bit   enq_en = 1'b1;
   int   enq_run = 0, deq_run = 0;
   int   last_enq_w = 0, last_deq_w = 0;
   int   enq_pulses = 0, deq_pulses = 0;
   int   ack_pulses = 0, ack_cycles = 0;
   int   gap = 0, last_gap = 0;
   int   ord = 0;
   logic prev_ack = 1'b0;
   logic [7:0] last_enq_data = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // one clock: sample outputs 1 time unit after the edge, update queue/deser models
   task automatic step();
      @(posedge clock_100KHZ);
      #1;
      if (q.ack_out) begin
         ack_cycles++;
         if (!prev_ack) begin
            ack_pulses++;
            last_gap = gap;
            q.data_ready_in = 1'b0;
         end
      end
      prev_ack = q.ack_out;
      if (q.enqueue_out) begin
         if (enq_run == 0) ord = ord * 16 + 1;
         enq_run++;
         last_enq_data = q.queue_data_out;
      end else if (enq_run > 0) begin
         last_enq_w = enq_run;
         enq_pulses++;
         if (enq_en && len_m < 8) len_m++;
         enq_run = 0;
         gap = 1;
      end else begin
         gap++;
      end
      if (q.dequeue_out) begin
         if (deq_run == 0) ord = ord * 16 + 2;
         deq_run++;
      end else if (deq_run > 0) begin
         last_deq_w = deq_run;
         deq_pulses++;
         if (len_m > 0) len_m--;
         deq_run = 0;
      end
      q.queue_len_in = 4'(len_m);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_ack(input string tag, input int limit);
      int start;
      start = ack_pulses;
      for (int i = 0; i < limit; i++) begin
         if (ack_pulses != start) break;
         step();
      end
      chk(tag, ack_pulses, start + 1);
   endtask

   task automatic pulse_deq();
      dequeue_req_in = 1'b1;
      step();
      dequeue_req_in = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enq_run = 0;
      deq_run = 0;
      steps(2);
      reset = 1'b0;
      step();
   endtask

   initial begin
      int e0, a0, d0;
      reset            = 1'b1;
      dequeue_req_in   = 1'b0;
      q.data_ready_in  = 1'b0;
      q.deser_data_in  = 8'h00;
      q.queue_len_in   = 4'h0;
      steps(3);

      // reset state
      chk("rst_enq",   q.enqueue_out, 1'b0);
      chk("rst_deq",   q.dequeue_out, 1'b0);
      chk("rst_ack",   q.ack_out, 1'b0);
      chk("rst_busy",  busy_out, 1'b0);
      chk("rst_full",  full_out, 1'b0);
      chk("rst_empty", empty_out, 1'b1);
      chk("rst_err",   err_out, 1'b0);
      chk("rst_data",  q.queue_data_out, 8'h00);
      reset = 1'b0;
      steps(2);

      // single write of 0xA5
      ord = 0;
      q.deser_data_in = 8'hA5;
      q.data_ready_in = 1'b1;
      step();
      chk("wr_strobe_lat", q.enqueue_out, 1'b1);
      chk("wr_data_early", q.queue_data_out, 8'hA5);
      wait_ack("wr_ack", 60);
      chk("wr_width",  last_enq_w, 10);
      chk("wr_data",   last_enq_data, 8'hA5);
      chk("wr_ack_w",  ack_cycles, 1);
      chk("wr_settle", last_gap, 3);
      steps(5);
      chk("wr_len",    len_m, 1);
      chk("wr_err",    err_out, 1'b0);
      chk("wr_idle",   busy_out, 1'b0);
      chk("wr_empty",  empty_out, 1'b0);

      // write and dequeue request in the same cycle after reset
      do_reset();
      len_m = 3;
      steps(4);
      ord = 0;
      q.deser_data_in = 8'h3C;
      q.data_ready_in = 1'b1;
      pulse_deq();
      wait_ack("ct_ack", 60);
      steps(30);
      chk("ct_order", ord, 32'h12);
      chk("ct_len",   len_m, 3);
      chk("ct_deq_w", last_deq_w, 10);
      chk("ct_err",   err_out, 1'b0);

      // true contention: both eligible when a dequeue finishes, enqueue wins
      ord = 0;
      pulse_deq();
      steps(3);
      q.deser_data_in = 8'h77;
      q.data_ready_in = 1'b1;
      pulse_deq();
      steps(80);
      chk("rr_order", ord, 32'h212);
      chk("rr_len",   len_m, 2);
      chk("rr_data",  last_enq_data, 8'h77);
      chk("rr_idle",  busy_out, 1'b0);

      // full queue holds the byte back until a dequeue makes room
      len_m = 8;
      steps(4);
      chk("fu_full", full_out, 1'b1);
      e0 = enq_pulses;
      a0 = ack_pulses;
      ord = 0;
      q.deser_data_in = 8'h5A;
      q.data_ready_in = 1'b1;
      steps(100);
      chk("fu_no_enq", enq_pulses, e0);
      chk("fu_no_ack", ack_pulses, a0);
      pulse_deq();
      wait_ack("fu_ack", 80);
      chk("fu_order", ord, 32'h21);
      chk("fu_data",  last_enq_data, 8'h5A);
      steps(5);
      chk("fu_len",   len_m, 8);

      // empty queue keeps merged dequeue requests pending
      len_m = 0;
      steps(4);
      chk("em_empty", empty_out, 1'b1);
      d0 = deq_pulses;
      for (int i = 0; i < 3; i++) begin
         pulse_deq();
         steps(3);
      end
      steps(30);
      chk("em_no_deq", deq_pulses, d0);
      chk("em_idle",   busy_out, 1'b0);
      q.deser_data_in = 8'h11;
      q.data_ready_in = 1'b1;
      steps(80);
      chk("em_one_deq", deq_pulses, d0 + 1);
      chk("em_deq_w",   last_deq_w, 10);
      chk("em_len",     len_m, 0);

      // queue ignores the write: settle times out, error sticks, ack still issued
      enq_en = 1'b0;
      chk("to_err_pre", err_out, 1'b0);
      q.deser_data_in = 8'h99;
      q.data_ready_in = 1'b1;
      wait_ack("to_ack", 80);
      chk("to_err",    err_out, 1'b1);
      chk("to_settle", last_gap, 20);
      steps(10);
      chk("to_sticky", err_out, 1'b1);
      chk("to_idle",   busy_out, 1'b0);
      enq_en = 1'b1;

      // reset during the fourth strobe cycle, then the byte is re-written
      e0 = enq_pulses;
      q.deser_data_in = 8'hC3;
      q.data_ready_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (enq_run == 4) break;
         step();
      end
      chk("mr_reached", enq_run, 4);
      reset = 1'b1;
      enq_run = 0;
      #1;
      chk("mr_enq",   q.enqueue_out, 1'b0);
      chk("mr_busy",  busy_out, 1'b0);
      chk("mr_err",   err_out, 1'b0);
      chk("mr_empty", empty_out, 1'b1);
      chk("mr_data",  q.queue_data_out, 8'h00);
      steps(2);
      reset = 1'b0;
      wait_ack("mr_ack", 80);
      chk("mr_width", last_enq_w, 10);
      chk("mr_redata", last_enq_data, 8'hC3);
      chk("mr_pulses", enq_pulses, e0 + 1);
      steps(3);
      chk("mr_len", len_m, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
